mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Latches one instruction per cycle and issues at most one load or store to the data memory port.
- Holds the pipeline while the memory reports busy, then sign- or zero-extends load data and presents the writeback record.
- Non-memory instructions pass the ALU result through with one cycle of latency.

Parameters:
ADDR_W  32  byte address width
DATA_W  32  data width; must be 32

Ports:
clk  in  1  clock
reset  in  1  reset (synchronous, active-high)
clr  in  1  flush: bubble into stage register instead of capturing inputs
i_valid  in  1  upstream instruction valid
i_mem_op  in  2  0=none, 1=load, 2=store, 3=reserved (treated as none)
i_mem_funct  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
i_addr  in  ADDR_W  ALU result; byte address for memory ops
i_store_data  in  DATA_W  store data, right-aligned
i_dest_en  in  1  instruction writes rd
i_dest_reg  in  5  rd index
o_stall  out  1  upstream must hold its outputs
o_mem_req_addr  out  ADDR_W  request byte address
o_mem_req_wr_data  out  DATA_W  store data, right-aligned, upper unused bytes zero
o_mem_req_wr_en  out  1  1=store, 0=load
o_mem_req_count  out  3  bytes requested: 0=no request, 1, 2, 4
i_mem_res_rd_data  in  DATA_W  load data, right-aligned
i_mem_res_code  in  2  0=BUSY, 1=DONE, 2=FAULT, 3=reserved (treated as FAULT)
o_valid  out  1  writeback record valid
o_dest_en  out  1  write rd (forced 0 on fault)
o_dest_reg  out  5  rd index
o_wb_data  out  DATA_W  writeback data
o_fault  out  1  one-cycle pulse: misaligned access or memory FAULT

Behaviour:
- Reset: all outputs 0 on the next edge; FSM to IDLE; stage register invalid; an outstanding access is abandoned (o_mem_req_count=0).
- Stage register captures inputs on every edge where o_stall=0. If clr=1, it captures a bubble (valid=0). When o_stall=1, clr is ignored.
- A captured memory op with funct3 outside the listed set is treated as misaligned.
- FSM state IDLE:
  - No valid memory op in the stage register: o_mem_req_count=0 and o_stall=0. Next edge registers o_valid=s_valid, o_wb_data=s_addr, o_dest_en/o_dest_reg passed through.
  - Valid memory op, misaligned (H with addr[0]=1, W with addr[1:0]!=0, or illegal funct3): no request issued; next edge sets o_valid=1, o_fault=1, o_dest_en=0.
  - Valid aligned memory op: request driven combinationally from the stage register. count = 1/2/4 per funct3[1:0]; wr_en = store; wr_data is store data masked to count bytes.
    - DONE this cycle: completes as below, o_stall=0.
    - BUSY: o_stall=1, next state ACCESS.
    - FAULT: o_valid=1, o_fault=1, o_dest_en=0 on next edge; o_stall=0.
- FSM state ACCESS:
  - Request held stable.
  - BUSY: o_stall=1, remain.
  - DONE or FAULT: complete as above, o_stall=0 this cycle, return to IDLE.
- Completion:
  - o_wb_data for loads is i_mem_res_rd_data, extended: B/H sign-extended from bit 7/15; BU/HU zero-extended.
  - o_wb_data for stores is 0, with o_dest_en=0.
  - o_valid for a non-completing cycle is 0 (bubble to writeback).
- Latency: DONE in the issue cycle gives 1 cycle (capture edge to o_valid edge), identical to non-memory ops. Each BUSY cycle adds 1.
- Back-to-back: a new instruction is captured on the same edge that registers the previous result.
- i_mem_res_code is ignored whenever o_mem_req_count=0.

Test Plan:
- Non-mem op: addr=0x1234, dest_en=1, rd=5 -> next cycle o_valid=1, o_wb_data=0x1234, rd=5; count stays 0.
- LB at 0x103, memory DONE same cycle with data 0x00000080 -> o_wb_data=0xFFFFFF80; LBU with same data -> 0x00000080; o_stall never set.
- SW at 0x200 with data 0xDEADBEEF, memory BUSY 3 cycles then DONE -> o_stall high exactly 3 cycles; addr/wr_data/wr_en=1/count=4 stable throughout; o_dest_en=0.
- LH at 0x101 -> count=0, o_valid=1, o_fault=1, o_dest_en=0 next cycle; LW at 0x102 -> same.
- LW with memory FAULT after 1 BUSY -> o_fault pulses 1 cycle, o_dest_en=0; next instruction then captured.
- reset asserted in ACCESS -> count=0 and all outputs 0 after the edge; clr while o_stall=1 -> outstanding access still completes.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. It latches one instruction per cycle from
// execute and issues at most one load or store to the data memory port. While
// memory reports busy it holds the pipeline. Load data is sign- or
// zero-extended before the writeback record is presented. Non-memory
// instructions reach writeback one cycle after capture.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // load extension and store masking assume 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              i_valid,
  input  logic [1:0]        i_mem_op,
  input  logic [2:0]        i_mem_funct,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic              i_dest_en,
  input  logic [4:0]        i_dest_reg,
  output logic              o_stall,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [DATA_W-1:0] o_mem_req_wr_data,
  output logic              o_mem_req_wr_en,
  output logic [2:0]        o_mem_req_count,
  input  logic [DATA_W-1:0] i_mem_res_rd_data,
  input  logic [1:0]        i_mem_res_code,
  output logic              o_valid,
  output logic              o_dest_en,
  output logic [4:0]        o_dest_reg,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_fault
);

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] RES_BUSY = 2'd0;
  localparam logic [1:0] RES_DONE = 2'd1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e            state;

  // Stage register
  logic              s_valid;
  logic [1:0]        s_mem_op;
  logic [2:0]        s_funct;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_store_data;
  logic              s_dest_en;
  logic [4:0]        s_dest_reg;

  // Decode of the held instruction
  logic              is_mem;
  logic              is_store;
  logic              legal;
  logic              misaligned;
  logic              req_active;
  logic [2:0]        req_count;
  logic [DATA_W-1:0] store_masked;
  logic [DATA_W-1:0] load_ext;
  logic              res_busy;
  logic              res_done;

  assign is_mem   = s_valid && (s_mem_op == OP_LOAD || s_mem_op == OP_STORE);
  assign is_store = (s_mem_op == OP_STORE);
  assign res_busy = (i_mem_res_code == RES_BUSY);
  assign res_done = (i_mem_res_code == RES_DONE);

  // Classify the access: legal funct3, alignment, size and store mask.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    legal        = 1'b0;
    req_count    = 3'd0;
    store_masked = '0;
    case (s_funct)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !is_store;  // unsigned forms are load-only
      default:                legal = 1'b0;
    endcase
    misaligned = !legal
               || (s_funct[1:0] == 2'b01 && s_addr[0])
               || (s_funct[1:0] == 2'b10 && s_addr[1:0] != 2'b00);
    req_active = is_mem && !misaligned;
    if (req_active) begin
      case (s_funct[1:0])
        2'b00: begin
          req_count    = 3'd1;
          store_masked = s_store_data & DATA_W'(32'h0000_00FF);
        end
        2'b01: begin
          req_count    = 3'd2;
          store_masked = s_store_data & DATA_W'(32'h0000_FFFF);
        end
        default: begin
          req_count    = 3'd4;
          store_masked = s_store_data;
        end
      endcase
    end
  end

  // Extend returned load data to the register width.
  always_comb begin
    case (s_funct)
      3'b000:  load_ext = {{24{i_mem_res_rd_data[7]}},  i_mem_res_rd_data[7:0]};
      3'b001:  load_ext = {{16{i_mem_res_rd_data[15]}}, i_mem_res_rd_data[15:0]};
      3'b100:  load_ext = {24'd0, i_mem_res_rd_data[7:0]};
      3'b101:  load_ext = {16'd0, i_mem_res_rd_data[15:0]};
      default: load_ext = i_mem_res_rd_data;
    endcase
  end

  // The request comes straight from the stage register, which cannot change
  // while stalled, so it stays stable for the whole access.
  assign o_mem_req_count   = req_count;
  assign o_mem_req_addr    = req_active ? s_addr : '0;
  assign o_mem_req_wr_data = store_masked;
  assign o_mem_req_wr_en   = req_active && is_store;
  assign o_stall           = req_active && res_busy;

  // Capture the next instruction whenever the stage is not stalled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid      <= 1'b0;
      s_mem_op     <= '0;
      s_funct      <= '0;
      s_addr       <= '0;
      s_store_data <= '0;
      s_dest_en    <= 1'b0;
      s_dest_reg   <= '0;
    end else if (!o_stall) begin
      if (clr) begin
        s_valid      <= 1'b0;
        s_mem_op     <= '0;
        s_funct      <= '0;
        s_addr       <= '0;
        s_store_data <= '0;
        s_dest_en    <= 1'b0;
        s_dest_reg   <= '0;
      end else begin
        s_valid      <= i_valid;
        s_mem_op     <= i_mem_op;
        s_funct      <= i_mem_funct;
        s_addr       <= i_addr;
        s_store_data <= i_store_data;
        s_dest_en    <= i_dest_en;
        s_dest_reg   <= i_dest_reg;
      end
    end
  end

  // Access FSM and registered writeback record.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      o_valid    <= 1'b0;
      o_dest_en  <= 1'b0;
      o_dest_reg <= '0;
      o_wb_data  <= '0;
      o_fault    <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (req_active && res_busy)   state <= ACCESS;
        ACCESS:  if (!req_active || !res_busy) state <= IDLE;
        default: state <= IDLE;
      endcase

      o_dest_reg <= s_dest_reg;
      if (!is_mem) begin
        // Non-memory instruction or bubble: pass the ALU result through.
        o_valid   <= s_valid;
        o_dest_en <= s_dest_en;
        o_wb_data <= DATA_W'(s_addr);
        o_fault   <= 1'b0;
      end else if (misaligned) begin
        o_valid   <= 1'b1;
        o_dest_en <= 1'b0;
        o_wb_data <= '0;
        o_fault   <= 1'b1;
      end else if (res_busy) begin
        // Still waiting on memory: bubble into writeback.
        o_valid   <= 1'b0;
        o_dest_en <= 1'b0;
        o_wb_data <= '0;
        o_fault   <= 1'b0;
      end else if (!res_done) begin
        // FAULT, or the reserved code treated as FAULT.
        o_valid   <= 1'b1;
        o_dest_en <= 1'b0;
        o_wb_data <= '0;
        o_fault   <= 1'b1;
      end else begin
        o_valid   <= 1'b1;
        o_dest_en <= is_store ? 1'b0 : s_dest_en;
        o_wb_data <= is_store ? '0 : load_ext;
        o_fault   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of single-access vectors plus
// hand-written sequences for stalls, faults, reset and flush during an access.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        i_valid;
  logic [1:0]  i_mem_op;
  logic [2:0]  i_mem_funct;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic        i_dest_en;
  logic [4:0]  i_dest_reg;
  logic        o_stall;
  logic [31:0] o_mem_req_addr;
  logic [31:0] o_mem_req_wr_data;
  logic        o_mem_req_wr_en;
  logic [2:0]  o_mem_req_count;
  logic [31:0] i_mem_res_rd_data;
  logic [1:0]  i_mem_res_code;
  logic        o_valid;
  logic        o_dest_en;
  logic [4:0]  o_dest_reg;
  logic [31:0] o_wb_data;
  logic        o_fault;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .clr               (clr),
    .i_valid           (i_valid),
    .i_mem_op          (i_mem_op),
    .i_mem_funct       (i_mem_funct),
    .i_addr            (i_addr),
    .i_store_data      (i_store_data),
    .i_dest_en         (i_dest_en),
    .i_dest_reg        (i_dest_reg),
    .o_stall           (o_stall),
    .o_mem_req_addr    (o_mem_req_addr),
    .o_mem_req_wr_data (o_mem_req_wr_data),
    .o_mem_req_wr_en   (o_mem_req_wr_en),
    .o_mem_req_count   (o_mem_req_count),
    .i_mem_res_rd_data (i_mem_res_rd_data),
    .i_mem_res_code    (i_mem_res_code),
    .o_valid           (o_valid),
    .o_dest_en         (o_dest_en),
    .o_dest_reg        (o_dest_reg),
    .o_wb_data         (o_wb_data),
    .o_fault           (o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] BUSY  = 2'd0;
  localparam logic [1:0] DONE  = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [1:0]  code;
    logic [2:0]  count;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        fault;
    logic        dest_en;
    logic [31:0] wb;
  } vec_t;

  typedef struct {
    logic        dest_en;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[16];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] funct, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic den, input logic [4:0] rd);
    i_valid      = 1'b1;
    i_mem_op     = op;
    i_mem_funct  = funct;
    i_addr       = addr;
    i_store_data = sdata;
    i_dest_en    = den;
    i_dest_reg   = rd;
  endtask

  task automatic idle_in();
    i_valid      = 1'b0;
    i_mem_op     = 2'd0;
    i_mem_funct  = 3'd0;
    i_addr       = 32'd0;
    i_store_data = 32'd0;
    i_dest_en    = 1'b0;
    i_dest_reg   = 5'd0;
  endtask

  task automatic push(input logic den, input logic [4:0] rd, input logic [31:0] wb, input logic f);
    exp_t e;
    e.dest_en = den;
    e.rd      = rd;
    e.wb      = wb;
    e.fault   = f;
    sb.push_back(e);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] funct, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata, input logic [1:0] code,
                              input logic [2:0] count, input logic wr_en, input logic [31:0] wr_data,
                              input logic fault, input logic dest_en, input logic [31:0] wb);
    vec_t v;
    v.op = op; v.funct = funct; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.code = code;
    v.count = count; v.wr_en = wr_en; v.wr_data = wr_data; v.fault = fault; v.dest_en = dest_en;
    v.wb = wb;
    return v;
  endfunction

  // Scoreboard monitor: every writeback record pops the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(o_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("wb_fault", 32'(o_fault), 32'(mon_e.fault));
          check("wb_dest_en", 32'(o_dest_en), 32'(mon_e.dest_en));
          if (mon_e.dest_en) check("wb_dest_reg", 32'(o_dest_reg), 32'(mon_e.rd));
          if (!mon_e.fault) check("wb_data", o_wb_data, mon_e.wb);
        end
      end else begin
        check("bubble_fault", 32'(o_fault), 32'd0);
      end
    end
  end

  initial begin
    int stall_cnt;
    vecs[0]  = mk(2'd0, 3'b000, 32'h1234, 32'h0, 32'h0, BUSY, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234);
    vecs[1]  = mk(2'd1, 3'b000, 32'h103, 32'h0, 32'h80, DONE, 3'd1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80);
    vecs[2]  = mk(2'd1, 3'b100, 32'h103, 32'h0, 32'h80, DONE, 3'd1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0080);
    vecs[3]  = mk(2'd1, 3'b001, 32'h102, 32'h0, 32'h8001, DONE, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001);
    vecs[4]  = mk(2'd1, 3'b101, 32'h102, 32'h0, 32'h1234_8001, DONE, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_8001);
    vecs[5]  = mk(2'd1, 3'b010, 32'h104, 32'h0, 32'hCAFE_F00D, DONE, 3'd4, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
    vecs[6]  = mk(2'd2, 3'b000, 32'h201, 32'hDEAD_BEEF, 32'h0, DONE, 3'd1, 1'b1, 32'hEF, 1'b0, 1'b0, 32'h0);
    vecs[7]  = mk(2'd2, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h0, DONE, 3'd2, 1'b1, 32'hBEEF, 1'b0, 1'b0, 32'h0);
    vecs[8]  = mk(2'd1, 3'b001, 32'h101, 32'h0, 32'h0, BUSY, 3'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    vecs[9]  = mk(2'd1, 3'b010, 32'h102, 32'h0, 32'h0, BUSY, 3'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    vecs[10] = mk(2'd1, 3'b010, 32'h100, 32'h0, 32'h0, FAULT, 3'd4, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    vecs[11] = mk(2'd1, 3'b011, 32'h100, 32'h0, 32'h0, BUSY, 3'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    vecs[12] = mk(2'd3, 3'b010, 32'h55, 32'h0, 32'h0, BUSY, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55);
    vecs[13] = mk(2'd2, 3'b100, 32'h100, 32'h12, 32'h0, BUSY, 3'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    vecs[14] = mk(2'd1, 3'b000, 32'h100, 32'h0, 32'h0, 2'd3, 3'd1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    vecs[15] = mk(2'd2, 3'b010, 32'h300, 32'h0123_4567, 32'h0, DONE, 3'd4, 1'b1, 32'h0123_4567, 1'b0, 1'b0, 32'h0);

    // Reset
    reset = 1'b1;
    clr   = 1'b0;
    idle_in();
    i_mem_res_rd_data = 32'h0;
    i_mem_res_code    = BUSY;
    step();
    step();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_count", 32'(o_mem_req_count), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_wb_data", o_wb_data, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Table: one instruction, response in the issue cycle, result one edge later
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].op, vecs[i].funct, vecs[i].addr, vecs[i].sdata, 1'b1, 5'(i + 5));
      push(vecs[i].dest_en, 5'(i + 5), vecs[i].wb, vecs[i].fault);
      i_mem_res_code = BUSY;
      step();
      idle_in();
      i_mem_res_rd_data = vecs[i].rdata;
      i_mem_res_code    = vecs[i].code;
      #1;
      check($sformatf("v%0d_count", i), 32'(o_mem_req_count), 32'(vecs[i].count));
      check($sformatf("v%0d_stall", i), 32'(o_stall), 32'd0);
      if (vecs[i].count != 3'd0) begin
        check($sformatf("v%0d_addr", i), o_mem_req_addr, vecs[i].addr);
        check($sformatf("v%0d_wr_en", i), 32'(o_mem_req_wr_en), 32'(vecs[i].wr_en));
        check($sformatf("v%0d_wr_data", i), o_mem_req_wr_data, vecs[i].wr_data);
      end
      step();
      check($sformatf("v%0d_latency", i), 32'(o_valid), 32'd1);
    end
    i_mem_res_code = BUSY;
    step();

    // SW busy for three cycles, next instruction held upstream and captured
    // on the completion edge
    drive(2'd2, 3'b010, 32'h200, 32'hDEAD_BEEF, 1'b1, 5'd7);
    push(1'b0, 5'd7, 32'h0, 1'b0);
    step();
    drive(2'd0, 3'b000, 32'h77, 32'h0, 1'b1, 5'd9);
    i_mem_res_code = BUSY;
    stall_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (o_stall) stall_cnt++;
      check("sw_count", 32'(o_mem_req_count), 32'd4);
      check("sw_addr", o_mem_req_addr, 32'h200);
      check("sw_wr_data", o_mem_req_wr_data, 32'hDEAD_BEEF);
      check("sw_wr_en", 32'(o_mem_req_wr_en), 32'd1);
      step();
    end
    i_mem_res_code = DONE;
    #1;
    check("sw_done_stall", 32'(o_stall), 32'd0);
    check("sw_done_count", 32'(o_mem_req_count), 32'd4);
    push(1'b1, 5'd9, 32'h77, 1'b0);
    step();
    check("sw_stall_cycles", 32'(stall_cnt), 32'd3);
    check("sw_result_valid", 32'(o_valid), 32'd1);
    idle_in();
    i_mem_res_code = BUSY;
    step();
    check("b2b_valid", 32'(o_valid), 32'd1);

    // LW: one BUSY cycle then FAULT
    drive(2'd1, 3'b010, 32'h400, 32'h0, 1'b1, 5'd10);
    push(1'b0, 5'd10, 32'h0, 1'b1);
    step();
    drive(2'd0, 3'b000, 32'h88, 32'h0, 1'b1, 5'd11);
    i_mem_res_code = BUSY;
    #1;
    check("lwf_stall", 32'(o_stall), 32'd1);
    step();
    i_mem_res_code = FAULT;
    #1;
    check("lwf_fault_stall", 32'(o_stall), 32'd0);
    push(1'b1, 5'd11, 32'h88, 1'b0);
    step();
    check("lwf_fault_pulse", 32'(o_fault), 32'd1);
    idle_in();
    i_mem_res_code = BUSY;
    step();
    check("lwf_fault_clear", 32'(o_fault), 32'd0);
    check("lwf_next_valid", 32'(o_valid), 32'd1);

    // Reset while the access is outstanding
    drive(2'd1, 3'b010, 32'h500, 32'h0, 1'b1, 5'd12);
    step();
    idle_in();
    i_mem_res_code = BUSY;
    step();
    check("rsta_stall", 32'(o_stall), 32'd1);
    sb.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rsta_count", 32'(o_mem_req_count), 32'd0);
    check("rsta_stall0", 32'(o_stall), 32'd0);
    check("rsta_valid", 32'(o_valid), 32'd0);
    check("rsta_dest_reg", 32'(o_dest_reg), 32'd0);
    check("rsta_req_addr", o_mem_req_addr, 32'd0);
    check("rsta_wr_en", 32'(o_mem_req_wr_en), 32'd0);
    step();

    // Flush while stalled: the access still completes, then a bubble follows
    drive(2'd1, 3'b010, 32'h300, 32'h0, 1'b1, 5'd13);
    push(1'b1, 5'd13, 32'h1122_3344, 1'b0);
    step();
    drive(2'd0, 3'b000, 32'h99, 32'h0, 1'b1, 5'd14);
    clr = 1'b1;
    i_mem_res_code = BUSY;
    #1;
    check("clr_stall", 32'(o_stall), 32'd1);
    step();
    check("clr_held_count", 32'(o_mem_req_count), 32'd4);
    check("clr_held_addr", o_mem_req_addr, 32'h300);
    i_mem_res_rd_data = 32'h1122_3344;
    i_mem_res_code    = DONE;
    step();
    check("clr_completed", 32'(o_valid), 32'd1);
    clr = 1'b0;
    idle_in();
    i_mem_res_code = BUSY;
    step();
    check("clr_bubble", 32'(o_valid), 32'd0);
    step();
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
